// File: rtl/wm_key_ctrl.sv
// Washing-machine panel input controller: per-key sync/debounce, selection
// rotation for the four option keys, and the start/pause/abort state machine.

module wm_key_db #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rstn,
  input  logic tick,
  input  logic key_n,
  output logic stable,
  output logic press,
  output logic rel
);
  localparam int DW = $clog2(DEBOUNCE_MS + 1);

  logic          s1, s2;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      press <= 1'b0;
      rel   <= 1'b0;
      if (tick) begin
        if (s2 != stable) begin
          if (cnt == DW'(DEBOUNCE_MS - 1)) begin
            stable <= s2;
            cnt    <= '0;
            press  <= ~s2;
            rel    <= s2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end
endmodule

module wm_key_ctrl #(
  parameter int CNT_1MSEC   = 125000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_course_n,
  input  logic       key_water_n,
  input  logic       key_temp_n,
  input  logic       key_repeat_n,
  input  logic       key_start_n,
  output logic [2:0] course_sel,
  output logic [2:0] water_sel,
  output logic [2:0] temp_sel,
  output logic [1:0] repeat_cnt,
  output logic [1:0] run_state,
  output logic       start_pulse,
  output logic       abort_pulse
);
  localparam int NUM_KEYS = 5;
  localparam int K_START  = 4;
  localparam int MSW      = (CNT_1MSEC > 1) ? $clog2(CNT_1MSEC) : 1;
  localparam int HW       = $clog2(LONG_MS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  logic [MSW-1:0]      ms_cnt;
  logic                tick_1ms;
  logic [NUM_KEYS-1:0] key_n, stable, press, rel;
  logic [HW-1:0]       hold;
  logic                long_ev, short_rel;
  state_t              state_q, state_d;
  logic                start_d, abort_d;
  logic                unused_keys;

  assign tick_1ms = (ms_cnt == MSW'(CNT_1MSEC - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         ms_cnt <= '0;
    else if (tick_1ms) ms_cnt <= '0;
    else               ms_cnt <= ms_cnt + 1'b1;
  end

  assign key_n = {key_start_n, key_repeat_n, key_temp_n, key_water_n, key_course_n};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    wm_key_db #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db (
      .clk   (clk),
      .rstn  (rstn),
      .tick  (tick_1ms),
      .key_n (key_n[g]),
      .stable(stable[g]),
      .press (press[g]),
      .rel   (rel[g])
    );
  end

  assign unused_keys = ^{stable[K_START-1:0], rel[K_START-1:0], press[K_START]};

  // Saturating hold timer; a release seen with hold==LONG_MS is the tail of a long press
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold    <= '0;
      long_ev <= 1'b0;
    end else if (!stable[K_START]) begin
      long_ev <= 1'b0;
      if (tick_1ms && hold != HW'(LONG_MS)) begin
        hold    <= hold + 1'b1;
        long_ev <= (hold == HW'(LONG_MS - 1));
      end
    end else begin
      hold    <= '0;
      long_ev <= 1'b0;
    end
  end

  assign short_rel = rel[K_START] && (hold < HW'(LONG_MS));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      course_sel <= 3'b001;
      water_sel  <= 3'b010;
      temp_sel   <= 3'b100;
      repeat_cnt <= 2'd1;
    end else if (state_q == IDLE) begin
      if (press[0]) course_sel <= {course_sel[1:0], course_sel[2]};
      if (press[1]) water_sel  <= {water_sel[1:0], water_sel[2]};
      if (press[2]) temp_sel   <= {temp_sel[1:0], temp_sel[2]};
      if (press[3]) repeat_cnt <= (repeat_cnt == 2'd3) ? 2'd1 : repeat_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      start_pulse <= 1'b0;
      abort_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_pulse <= start_d;
      abort_pulse <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    if (long_ev && state_q != IDLE) begin
      state_d = IDLE;
      abort_d = 1'b1;
    end else if (short_rel) begin
      case (state_q)
        IDLE:    begin state_d = RUN; start_d = 1'b1; end
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  assign run_state = state_q;
endmodule

// File: tb/tb_wm_key_ctrl.sv
// Randomized and directed bench for wm_key_ctrl against a ms-level reference model.

module tb_wm_key_ctrl;
  localparam int CNT  = 10;
  localparam int DB   = 4;
  localparam int LONG = 50;

  logic       clk, rstn;
  logic [4:0] keys_n;
  logic [2:0] course_sel, water_sel, temp_sel;
  logic [1:0] repeat_cnt, run_state;
  logic       start_pulse, abort_pulse;

  wm_key_ctrl #(.CNT_1MSEC(CNT), .DEBOUNCE_MS(DB), .LONG_MS(LONG)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .key_course_n(keys_n[0]),
    .key_water_n (keys_n[1]),
    .key_temp_n  (keys_n[2]),
    .key_repeat_n(keys_n[3]),
    .key_start_n (keys_n[4]),
    .course_sel  (course_sel),
    .water_sel   (water_sel),
    .temp_sel    (temp_sel),
    .repeat_cnt  (repeat_cnt),
    .run_state   (run_state),
    .start_pulse (start_pulse),
    .abort_pulse (abort_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, sp_seen = 0, ap_seen = 0, chg_cnt = 0, chg_cyc = 0, tchg_cyc = 0;
  logic [2:0] prev_course = 3'b001, prev_temp = 3'b100;

  // Reference model: selections as rotation indices, run state as an integer
  int m_ms, m_hold, m_course, m_water, m_temp, m_rep, m_state;
  int m_dcnt[5];
  bit [4:0] m_s1, m_s2, m_stab, m_press, m_rel;
  bit m_long, m_sp, m_ap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ms = 0; m_hold = 0; m_long = 0;
    m_course = 0; m_water = 1; m_temp = 2; m_rep = 1; m_state = 0;
    m_sp = 0; m_ap = 0;
    m_s1 = '1; m_s2 = '1; m_stab = '1; m_press = '0; m_rel = '0;
    for (int k = 0; k < 5; k++) m_dcnt[k] = 0;
  endtask

  // Stages updated downstream-first so each reads the previous cycle's values
  task automatic model_step();
    bit tick;
    tick = (m_ms == CNT - 1);
    if (m_state == 0) begin
      if (m_press[0]) m_course = (m_course + 1) % 3;
      if (m_press[1]) m_water  = (m_water + 1) % 3;
      if (m_press[2]) m_temp   = (m_temp + 1) % 3;
      if (m_press[3]) m_rep    = (m_rep % 3) + 1;
    end
    m_sp = 0; m_ap = 0;
    if (m_long && m_state != 0) begin
      m_state = 0; m_ap = 1;
    end else if (m_rel[4] && m_hold < LONG) begin
      if (m_state == 0) begin m_state = 1; m_sp = 1; end
      else if (m_state == 1) m_state = 2;
      else m_state = 1;
    end
    m_long = 0;
    if (!m_stab[4]) begin
      if (tick && m_hold < LONG) begin
        m_hold++;
        m_long = (m_hold == LONG);
      end
    end else begin
      m_hold = 0;
    end
    m_press = '0; m_rel = '0;
    for (int k = 0; k < 5; k++) begin
      if (tick) begin
        if (m_s2[k] != m_stab[k]) begin
          m_dcnt[k]++;
          if (m_dcnt[k] == DB) begin
            m_stab[k] = m_s2[k];
            m_dcnt[k] = 0;
            if (m_stab[k]) m_rel[k] = 1; else m_press[k] = 1;
          end
        end else m_dcnt[k] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = keys_n;
    m_ms = tick ? 0 : m_ms + 1;
  endtask

  function automatic logic [14:0] exp_vec();
    logic [2:0] c, w, t;
    c = 3'b001 << m_course;
    w = 3'b001 << m_water;
    t = 3'b001 << m_temp;
    return {c, w, t, 2'(m_rep), 2'(m_state), m_sp, m_ap};
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!rstn) model_reset(); else model_step();
      @(negedge clk);
      cyc++;
      chk("cycle", {17'd0, course_sel, water_sel, temp_sel, repeat_cnt, run_state,
                    start_pulse, abort_pulse}, {17'd0, exp_vec()});
      if (start_pulse) sp_seen++;
      if (abort_pulse) ap_seen++;
      if (course_sel != prev_course) begin chg_cnt++; chg_cyc = cyc; end
      if (temp_sel != prev_temp) tchg_cyc = cyc;
      prev_course = course_sel;
      prev_temp   = temp_sel;
    end
  endtask

  task automatic press_key(input int k, input int hold_ms);
    keys_n[k] = 1'b0;
    step(hold_ms * CNT);
    keys_n[k] = 1'b1;
    step(7 * CNT);
  endtask

  task automatic chk_defaults(input string tag);
    chk({tag, "_course"}, course_sel, 3'b001);
    chk({tag, "_water"}, water_sel, 3'b010);
    chk({tag, "_temp"}, temp_sel, 3'b100);
    chk({tag, "_repeat"}, repeat_cnt, 2'd1);
    chk({tag, "_state"}, run_state, 2'd0);
    chk({tag, "_pulses"}, {start_pulse, abort_pulse}, 2'b00);
  endtask

  initial begin
    int last_t, k, dur;
    keys_n = '1;
    rstn   = 1'b0;
    model_reset();
    step(3);
    chk_defaults("reset");
    rstn = 1'b1;
    step(5);

    // Bounces shorter than the debounce window, then a clean low level
    chg_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      keys_n[0] = ~keys_n[0];
      step(2 * CNT);
    end
    keys_n[0] = 1'b0;
    last_t = cyc;
    step(5 * CNT);
    chk("bounce_changes", chg_cnt, 1);
    chk("bounce_delay_ok", ((chg_cyc - last_t) > 3 * CNT) && ((chg_cyc - last_t) <= 4 * CNT + 4), 1);
    chk("bounce_course", course_sel, 3'b010);
    keys_n[0] = 1'b1;
    step(7 * CNT);

    press_key(1, 7); chk("water1", water_sel, 3'b100);
    press_key(1, 7); chk("water2", water_sel, 3'b001);
    press_key(1, 7); chk("water3", water_sel, 3'b010);
    press_key(3, 7); chk("repeat1", repeat_cnt, 2'd2);
    press_key(3, 7); chk("repeat2", repeat_cnt, 2'd3);
    press_key(3, 7); chk("repeat3", repeat_cnt, 2'd1);

    sp_seen = 0; ap_seen = 0;
    press_key(4, 7); chk("start_run", run_state, 2'd1); chk("start_pulse_cnt", sp_seen, 1);
    press_key(4, 7); chk("pause", run_state, 2'd2);
    press_key(4, 7); chk("resume", run_state, 2'd1); chk("resume_no_pulse", sp_seen, 1);
    press_key(0, 7); chk("course_in_run", course_sel, 3'b010);

    keys_n[4] = 1'b0;
    step(60 * CNT);
    chk("abort_state", run_state, 2'd0);
    chk("abort_pulse_cnt", ap_seen, 1);
    keys_n[4] = 1'b1;
    step(7 * CNT);
    chk("post_long_release", run_state, 2'd0);
    chk("post_long_no_start", sp_seen, 1);
    keys_n[4] = 1'b0;
    step(60 * CNT);
    keys_n[4] = 1'b1;
    step(7 * CNT);
    chk("idle_long_state", run_state, 2'd0);
    chk("idle_long_pulses", sp_seen * 16 + ap_seen, 16 + 1);

    keys_n[0] = 1'b0; keys_n[2] = 1'b0;
    step(7 * CNT);
    chk("simul_course", course_sel, 3'b100);
    chk("simul_temp", temp_sel, 3'b001);
    chk("simul_same_cycle", chg_cyc, tchg_cyc);
    keys_n[0] = 1'b1; keys_n[2] = 1'b1;
    step(7 * CNT);

    // Key held across reset registers as a fresh press
    keys_n[1] = 1'b0;
    step(2 * CNT);
    rstn = 1'b0;
    step(2);
    chk_defaults("midpress");
    rstn = 1'b1;
    step(7 * CNT);
    chk("held_fresh_press", water_sel, 3'b100);
    keys_n[1] = 1'b1;
    step(7 * CNT);

    press_key(4, 7);
    rstn = 1'b0;
    step(2);
    chk_defaults("midrun");
    rstn = 1'b1;
    step(5);

    for (int seg = 0; seg < 250; seg++) begin
      k   = $urandom_range(0, 4);
      dur = ($urandom_range(0, 19) == 0) ? 600 : $urandom_range(1, 80);
      keys_n[k] = 1'($urandom_range(0, 1));
      step(dur);
      if ($urandom_range(0, 99) == 0) begin
        rstn = 1'b0;
        step(2);
        rstn = 1'b1;
      end
    end
    keys_n = '1;
    step(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wm_key_ctrl.md
Name: wm_key_ctrl

Overview:
Input-side panel controller for the washing machine. It debounces the front-panel pushbuttons and maintains the user selections: course, water height, temperature and repeat count. It also runs the start/pause/abort state machine. Its one-hot selection outputs drive the panel LED block, which lights one green LED per selection group.

Parameters:
CNT_1MSEC, 125000, clk cycles per 1 ms tick (125 MHz clock).
DEBOUNCE_MS, 20, consecutive stable ms required to accept a key level change (min 1).
LONG_MS, 1000, hold time in ms on key_start that counts as a long press (must be > DEBOUNCE_MS).

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
key_course_n  input  1  raw course button, active-low, asynchronous to clk
key_water_n  input  1  raw water-height button, active-low
key_temp_n  input  1  raw temperature button, active-low
key_repeat_n  input  1  raw repeat button, active-low
key_start_n  input  1  raw start/pause button, active-low
course_sel  output  3  one-hot: [0] wash, [1] rinse, [2] dry
water_sel  output  3  one-hot: [0] low, [1] mid, [2] high
temp_sel  output  3  one-hot: [0] cold only, [1] hot only, [2] hot+cold
repeat_cnt  output  2  repeat count, 1..3 (value 0 never driven)
run_state  output  2  0 IDLE, 1 RUN, 2 PAUSE
start_pulse  output  1  one-cycle pulse on IDLE->RUN
abort_pulse  output  1  one-cycle pulse on RUN/PAUSE->IDLE

Behaviour:
- Reset: clk, rstn; asynchronous, active-low.
- Reset values:
  - course_sel=3'b001, water_sel=3'b010, temp_sel=3'b100, repeat_cnt=2'd1.
  - run_state=IDLE; start_pulse=0, abort_pulse=0.
  - All synchronizers set to 1 (released); debounce and hold counters cleared.
- 1 ms tick: free-running counter 0..CNT_1MSEC-1. tick_1ms is high for one clk when the count equals CNT_1MSEC-1.
- Synchronizer: 2-FF per key, reset to 1.
- Debounce (per key):
  - Keep a stable level (reset 1) and a ms counter.
  - On each tick where the synced level differs from stable, the counter increments. When it reaches DEBOUNCE_MS, stable takes the synced level and the counter clears.
  - On any tick where synced equals stable, the counter clears.
  - Edge: press = stable 1->0, release = stable 0->1, each a one-cycle strobe in the cycle stable updates.
- Selection keys (course/water/temp/repeat) act on the press strobe, and only when run_state==IDLE. They are ignored in RUN/PAUSE.
  - course_sel rotates left: 001->010->100->001.
  - water_sel rotates left.
  - temp_sel rotates left.
  - repeat_cnt: 1->2->3->1.
  - Update is visible the cycle after the press strobe.
  - Different keys pressed in the same cycle each update their own group independently.
- Start key:
  - Hold counter counts ticks while stable==0; it saturates at LONG_MS and clears on release.
  - A long event fires once, in the cycle the counter reaches LONG_MS.
  - Short press: on release with hold < LONG_MS.
    - IDLE->RUN with start_pulse.
    - RUN->PAUSE.
    - PAUSE->RUN (no start_pulse).
  - Long press: RUN or PAUSE -> IDLE with abort_pulse. Selections keep their current values.
  - In IDLE a long press is ignored. Any release following a long event is ignored.
- Pulse timing: start_pulse and abort_pulse are asserted in the same cycle run_state updates.
- Reset mid-press or mid-run: everything returns to reset values. A key still held at reset deassertion needs DEBOUNCE_MS to register as a press (counts as a fresh press).

Test Plan:
- Reset and defaults: assert rstn=0 mid-operation -> course 001, water 010, temp 100, repeat 1, run_state 0, pulses 0.
- Bounce rejection (CNT_1MSEC=10, DEBOUNCE_MS=4): key_course_n toggles every 2 ms for 20 ms, then held low 5 ms -> exactly one course_sel change 001->010, occurring 4 ticks after the last toggle.
- Wrap-around: 3 clean water presses -> 010->100->001->010. 3 repeat presses -> 2,3,1.
- Start/pause: short start press -> RUN plus one start_pulse. Short press -> PAUSE. Short press -> RUN with no start_pulse. A course press while RUN -> course_sel unchanged.
- Long abort (LONG_MS=50): in RUN hold start 60 ms -> IDLE at hold=50 ms plus one abort_pulse. The following release causes no state change. A long hold in IDLE -> no change.
- Simultaneous keys: course and temp pressed in the same cycle while IDLE -> both groups rotate in the same cycle.
